// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter for the 4-way SDRAM multiplexer; parks oSelect at 0 between grants.
// Build option: SDRAM_ARB_HOST_PRIORITY_EN makes the host port (0) win whenever it requests.
module sdram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int PARK_CYCLES    = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iREQ,
  input  logic       iSDR_Done,
  output logic [1:0] oSelect,
  output logic [3:0] oGrant,
  output logic [3:0] oDone,
  output logic       oTimeout,
  output logic       oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PARK  = 2'd2
  } stateT;

  stateT            stateReg, stateNext;
  logic [1:0]       rrPtrReg, rrPtrNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [1:0]       selectReg, selectNext;
  logic [3:0]       grantReg, grantNext;
  logic [3:0]       doneReg, doneNext;
  logic             timeoutReg, timeoutNext;
  logic             busyReg, busyNext;

  logic [3:0]       arbReq;
  logic             hostReq;
  logic [3:0]       rotReq;
  logic [1:0]       winOff;
  logic [1:0]       winner;

  // With host priority the host bypasses the rotation; ports 1..3 share it.
`ifdef SDRAM_ARB_HOST_PRIORITY_EN
  assign arbReq  = {iREQ[3:1], 1'b0};
  assign hostReq = iREQ[0];
`else
  assign arbReq  = iREQ;
  assign hostReq = 1'b0;
`endif

  // rotReq[k] is the request of port (rrPtr + k) mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gRot
      assign rotReq[gi] = arbReq[rrPtrReg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    winOff = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rotReq[i]) winOff = 2'(i);
    end
    winner = rrPtrReg + winOff;
  end

  always_comb begin
    stateNext   = stateReg;
    rrPtrNext   = rrPtrReg;
    cntNext     = cntReg;
    selectNext  = selectReg;
    grantNext   = grantReg;
    doneNext    = 4'd0;
    timeoutNext = 1'b0;

    unique case (stateReg)
      IDLE: begin
        selectNext = 2'd0;
        grantNext  = 4'd0;
        if (hostReq) begin
          stateNext  = GRANT;
          selectNext = 2'd0;
          grantNext  = 4'b0001;
          cntNext    = '0;
        end else if (arbReq != 4'd0) begin
          stateNext  = GRANT;
          selectNext = winner;
          grantNext  = 4'b0001 << winner;
          rrPtrNext  = winner + 2'd1;
          cntNext    = '0;
        end
      end
      GRANT: begin
        cntNext = cntReg + 1'b1;
        // Done takes precedence over a timeout landing in the same cycle.
        if (iSDR_Done) begin
          stateNext  = PARK;
          doneNext   = grantReg;
          grantNext  = 4'd0;
          selectNext = 2'd0;
          cntNext    = '0;
        end else if (cntReg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          stateNext   = PARK;
          timeoutNext = 1'b1;
          grantNext   = 4'd0;
          selectNext  = 2'd0;
          cntNext     = '0;
        end
      end
      PARK: begin
        selectNext = 2'd0;
        grantNext  = 4'd0;
        if (cntReg == CNT_W'(PARK_CYCLES - 1)) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      default: begin
        stateNext  = IDLE;
        selectNext = 2'd0;
        grantNext  = 4'd0;
        cntNext    = '0;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg   <= IDLE;
      rrPtrReg   <= 2'd0;
      cntReg     <= '0;
      selectReg  <= 2'd0;
      grantReg   <= 4'd0;
      doneReg    <= 4'd0;
      timeoutReg <= 1'b0;
      busyReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      rrPtrReg   <= rrPtrNext;
      cntReg     <= cntNext;
      selectReg  <= selectNext;
      grantReg   <= grantNext;
      doneReg    <= doneNext;
      timeoutReg <= timeoutNext;
      busyReg    <= busyNext;
    end
  end

  assign oSelect  = selectReg;
  assign oGrant   = grantReg;
  assign oDone    = doneReg;
  assign oTimeout = timeoutReg;
  assign oBusy    = busyReg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (honours SDRAM_ARB_HOST_PRIORITY_EN when defined).
module tb_sdram_port_arbiter;

  localparam int TIMEOUT_CYCLES = 255;
  localparam int CNT_W          = 8;
  localparam int PARK_CYCLES    = 1;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [3:0] iREQ = 4'd0;
  logic       iSDR_Done = 1'b0;
  logic [1:0] oSelect;
  logic [3:0] oGrant;
  logic [3:0] oDone;
  logic       oTimeout;
  logic       oBusy;

  sdram_port_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W(CNT_W),
    .PARK_CYCLES(PARK_CYCLES)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iREQ(iREQ),
    .iSDR_Done(iSDR_Done),
    .oSelect(oSelect),
    .oGrant(oGrant),
    .oDone(oDone),
    .oTimeout(oTimeout),
    .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  // Model: which port holds the bus (-1 none), how long it has held it,
  // how many park cycles remain, and where the round-robin search starts.
  int         mPort = -1;
  int         mAge = 0;
  int         mPark = 0;
  int         mRr = 0;
  logic [3:0] eDone = 4'd0;
  logic       eTimeout = 1'b0;

  int gOrder[$];
  int gGaps[$];

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int ohIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int pickWinner(input logic [3:0] req);
`ifdef SDRAM_ARB_HOST_PRIORITY_EN
    if (req[0]) return 0;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (mRr + k) % 4;
      if (p != 0 && req[p]) return p;
    end
`else
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (mRr + k) % 4;
      if (req[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] req, input logic done, input logic rst);
    int w;
    eDone = 4'd0;
    eTimeout = 1'b0;
    if (rst) begin
      mPort = -1; mAge = 0; mPark = 0; mRr = 0;
    end else if (mPort >= 0) begin
      if (done) begin
        eDone = 4'(1 << mPort);
        mPort = -1;
        mPark = PARK_CYCLES;
      end else if (mAge == TIMEOUT_CYCLES - 1) begin
        eTimeout = 1'b1;
        mPort = -1;
        mPark = PARK_CYCLES;
      end else begin
        mAge++;
      end
    end else if (mPark > 0) begin
      mPark--;
    end else begin
      w = pickWinner(req);
      if (w >= 0) begin
        mPort = w;
        mAge = 0;
`ifdef SDRAM_ARB_HOST_PRIORITY_EN
        if (w != 0) mRr = (w + 1) % 4;
`else
        mRr = (w + 1) % 4;
`endif
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare all outputs just after.
  task automatic stepCycle(input logic [3:0] req, input logic done, input logic rst);
    logic [1:0] expSel;
    logic [3:0] expGrant;
    iREQ = req; iSDR_Done = done; iRST = rst;
    @(posedge iCLK);
    modelStep(req, done, rst);
    #1;
    cyc++;
    expSel   = (mPort < 0) ? 2'd0 : 2'(mPort);
    expGrant = (mPort < 0) ? 4'd0 : 4'(1 << mPort);
    checkEq("select", oSelect, expSel);
    checkEq("grant", oGrant, expGrant);
    checkEq("done", oDone, eDone);
    checkEq("timeout", oTimeout, eTimeout);
    checkEq("busy", oBusy, (mPort >= 0) || (mPark > 0));
    if (eDone != 4'd0) $display("[TB] cycle %0d: port %0d completed", cyc, ohIdx(eDone));
    if (eTimeout) $display("[TB] cycle %0d: forced release", cyc);
  endtask

  task automatic doReset();
    stepCycle(4'd0, 1'b0, 1'b1);
    stepCycle(4'd0, 1'b0, 1'b1);
  endtask

  // Hold req, answer each grant with Done three cycles in, log grant order and zero-grant gaps.
  task automatic runGrants(input logic [3:0] req, input int n);
    int sinceGrant, zeroRun, budget;
    gOrder.delete(); gGaps.delete();
    sinceGrant = -1; zeroRun = 0; budget = 0;
    while (gOrder.size() < n && budget < 200) begin
      stepCycle(req, sinceGrant == 3, 1'b0);
      budget++;
      if (oGrant != 4'd0) begin
        if (sinceGrant < 0) begin
          gOrder.push_back(ohIdx(oGrant));
          if (gOrder.size() > 1) gGaps.push_back(zeroRun);
          sinceGrant = 0;
        end else begin
          sinceGrant++;
        end
        zeroRun = 0;
      end else begin
        sinceGrant = -1;
        zeroRun++;
      end
    end
    checkEq("grant_budget", gOrder.size(), n);
  endtask

  initial begin
    int expOrder[5];
    int k;
    logic [3:0] reqState;

    // Reset state and single transfer on port 1
    doReset();
    checkEq("rst_busy", oBusy, 1'b0);
    checkEq("rst_grant", oGrant, 4'd0);
    stepCycle(4'b0010, 1'b0, 1'b0);
    checkEq("t1_grant", oGrant, 4'b0010);
    checkEq("t1_select", oSelect, 2'd1);
    for (int c = 1; c <= 4; c++) stepCycle(4'b0010, 1'b0, 1'b0);
    stepCycle(4'b0010, 1'b1, 1'b0);
    checkEq("t1_done", oDone, 4'b0010);
    checkEq("t1_sel0", oSelect, 2'd0);
    stepCycle(4'b0000, 1'b0, 1'b0);
    checkEq("t1_idle", oBusy, 1'b0);

    // Round robin among async ports
    doReset();
    runGrants(4'b1110, 4);
    expOrder = '{1, 2, 3, 1, 0};
    for (int i = 0; i < gOrder.size(); i++) checkEq("t2_order", gOrder[i], expOrder[i]);
    foreach (gGaps[i]) checkEq("t2_gap", gGaps[i], PARK_CYCLES + 1);

    // All four requesting
    doReset();
    runGrants(4'b1111, 5);
`ifdef SDRAM_ARB_HOST_PRIORITY_EN
    expOrder = '{0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < gOrder.size(); i++) checkEq("t3_order", gOrder[i], expOrder[i]);

    // Timeout on port 2
    doReset();
    stepCycle(4'b0100, 1'b0, 1'b0);
    checkEq("t4_grant", oGrant, 4'b0100);
    k = 0;
    while (k < 300 && !oTimeout) begin
      stepCycle(4'b0100, 1'b0, 1'b0);
      k++;
    end
    checkEq("t4_latency", k, TIMEOUT_CYCLES);
    checkEq("t4_nodone", oDone, 4'd0);
    checkEq("t4_sel0", oSelect, 2'd0);
    stepCycle(4'd0, 1'b0, 1'b0);
    stepCycle(4'd0, 1'b0, 1'b0);

    // Reset during grant of port 3, then during grant of port 2
    doReset();
    stepCycle(4'b1000, 1'b0, 1'b0);
    checkEq("t5_grant3", oGrant, 4'b1000);
    stepCycle(4'b1000, 1'b0, 1'b0);
    stepCycle(4'b1000, 1'b0, 1'b1);
    checkEq("t5_sel", oSelect, 2'd0);
    checkEq("t5_grant", oGrant, 4'd0);
    checkEq("t5_busy", oBusy, 1'b0);
    checkEq("t5_pulses", {oDone, oTimeout}, 5'd0);
    stepCycle(4'b1111, 1'b0, 1'b0);
    checkEq("t5_next", oGrant, 4'b0001);
    doReset();
    stepCycle(4'b0100, 1'b0, 1'b0);
    stepCycle(4'b0100, 1'b0, 1'b1);
    stepCycle(4'b1010, 1'b0, 1'b0);
    checkEq("t5_rrptr", oGrant, 4'b0010);

    // Done ignored in IDLE/PARK; Done coinciding with timeout
    doReset();
    stepCycle(4'd0, 1'b1, 1'b0);
    checkEq("t6_idle_done", oDone, 4'd0);
    stepCycle(4'b0010, 1'b0, 1'b0);
    stepCycle(4'b0010, 1'b1, 1'b0);
    checkEq("t6_done", oDone, 4'b0010);
    stepCycle(4'd0, 1'b1, 1'b0);
    checkEq("t6_park_done", oDone, 4'd0);
    doReset();
    stepCycle(4'b0100, 1'b0, 1'b0);
    for (int c = 0; c < TIMEOUT_CYCLES - 1; c++) stepCycle(4'b0100, 1'b0, 1'b0);
    stepCycle(4'b0100, 1'b1, 1'b0);
    checkEq("t6_tie_done", oDone, 4'b0100);
    checkEq("t6_tie_timeout", oTimeout, 1'b0);

    // Random traffic: requests held until their own completion pulse
    doReset();
    reqState = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++) if ($urandom_range(0, 7) == 0) reqState[p] = 1'b1;
      stepCycle(reqState, $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
      reqState = reqState & ~eDone;
      if ($urandom_range(0, 199) == 0) reqState = 4'd0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
